// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 encoder: latches a request vector and emits the binary
// index of each set bit, one per code transfer, in configurable priority order.
module encoder_8x3_seq #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req,
    output logic       code_valid,
    input  logic       code_ready,
    output logic [2:0] code,
    output logic       last,
    output logic [3:0] remaining,
    output logic       state_dbg
);

    // Handshake rule for both ports: a transfer happens on a rising edge where
    // valid and ready are both high; valid never waits on ready.
    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] pending;

    function automatic logic [2:0] pick_index(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 8; i++)
                if (v[i]) r = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--)
                if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++)
            n = n + 4'(v[i]);
        return n;
    endfunction

    // pending is all-zero in IDLE, so these decodes read zero there.
    always_comb begin
        code       = pick_index(pending);
        remaining  = count_ones(pending);
        last       = (remaining == 4'd1);
        code_valid = (state == SERVE);
        state_dbg  = state;
    end

    // req_ready is registered from en, so it follows en one cycle late;
    // acceptance itself still requires en at the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= 8'h00;
            req_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready && en && (req != 8'h00)) begin
                        pending   <= req;
                        state     <= SERVE;
                        req_ready <= 1'b0;
                    end else begin
                        req_ready <= en;
                    end
                end
                SERVE: begin
                    if (code_ready) begin
                        pending <= pending & ~(8'(1) << code);
                        if (last) begin
                            state     <= IDLE;
                            req_ready <= en;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    pending   <= 8'h00;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_8x3_seq.sv
// Bench for encoder_8x3_seq: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a queue model plus directed literals.
module tb_encoder_8x3_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b1;
    logic       req_valid = 1'b0;
    logic       code_ready = 1'b1;
    logic [7:0] req = 8'h00;

    logic       req_ready_a, code_valid_a, last_a, state_dbg_a;
    logic [2:0] code_a;
    logic [3:0] remaining_a;
    logic       req_ready_b, code_valid_b, last_b, state_dbg_b;
    logic [2:0] code_b;
    logic [3:0] remaining_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [2:0] code;
        logic       last;
        logic [3:0] rem;
        int         cyc;
    } ent_t;

    ent_t log_a[$];
    ent_t log_b[$];

    logic [2:0] q_a[$];
    logic [2:0] q_b[$];
    logic       exp_ready = 1'b0;
    bit         model_ok = 1'b0;

    encoder_8x3_seq #(.MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid),
        .req_ready(req_ready_a), .req(req), .code_valid(code_valid_a),
        .code_ready(code_ready), .code(code_a), .last(last_a),
        .remaining(remaining_a), .state_dbg(state_dbg_a)
    );

    encoder_8x3_seq #(.MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid),
        .req_ready(req_ready_b), .req(req), .code_valid(code_valid_b),
        .code_ready(code_ready), .code(code_b), .last(last_b),
        .remaining(remaining_b), .state_dbg(state_dbg_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a vector becomes a list of indices in service order.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a.delete();
            q_b.delete();
            exp_ready = 1'b0;
            model_ok  = 1'b1;
        end else begin
            if (q_a.size() > 0) begin
                if (code_ready) begin
                    void'(q_a.pop_front());
                    void'(q_b.pop_front());
                end
            end else if (exp_ready && en && req_valid) begin
                for (int i = 7; i >= 0; i--) if (req[i]) q_a.push_back(3'(i));
                for (int i = 0; i < 8; i++)  if (req[i]) q_b.push_back(3'(i));
            end
            exp_ready = (q_a.size() == 0) && en;
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (rst_n && code_valid_a && code_ready)
            log_a.push_back('{code: code_a, last: last_a, rem: remaining_a, cyc: cyc});
        if (rst_n && code_valid_b && code_ready)
            log_b.push_back('{code: code_b, last: last_b, rem: remaining_b, cyc: cyc});
    end

    always @(negedge clk) begin
        if (model_ok && rst_n) begin
            chk("cmp_ready_a", req_ready_a, exp_ready);
            chk("cmp_ready_b", req_ready_b, exp_ready);
            chk("cmp_valid_a", code_valid_a, q_a.size() > 0);
            chk("cmp_valid_b", code_valid_b, q_b.size() > 0);
            chk("cmp_state_a", state_dbg_a, q_a.size() > 0);
            chk("cmp_rem_a", remaining_a, q_a.size());
            chk("cmp_rem_b", remaining_b, q_b.size());
            chk("cmp_last_a", last_a, q_a.size() == 1);
            chk("cmp_last_b", last_b, q_b.size() == 1);
            if (q_a.size() > 0) chk("cmp_code_a", code_a, q_a[0]);
            if (q_b.size() > 0) chk("cmp_code_b", code_b, q_b[0]);
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_ready_a"}, req_ready_a, 0);
        chk({nm, "_valid_a"}, code_valid_a, 0);
        chk({nm, "_code_a"}, code_a, 0);
        chk({nm, "_last_a"}, last_a, 0);
        chk({nm, "_rem_a"}, remaining_a, 0);
        chk({nm, "_ready_b"}, req_ready_b, 0);
        chk({nm, "_valid_b"}, code_valid_b, 0);
        chk({nm, "_rem_b"}, remaining_b, 0);
    endtask

    task automatic send(input logic [7:0] v);
        bit done;
        done = 1'b0;
        req = v;
        req_valid = 1'b1;
        for (int n = 0; n < 60 && !done; n++) begin
            @(posedge clk);
            if (req_ready_a && en) done = 1'b1;
        end
        #1;
        req_valid = 1'b0;
        req = 8'h00;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            if (req_ready_a && !code_valid_a) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    task automatic clear_logs();
        log_a.delete();
        log_b.delete();
    endtask

    initial begin
        // Reset asserted between edges: outputs must clear without a clock.
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_release_ready", req_ready_a, 0);
        @(posedge clk);
        #1 chk("first_edge_ready", req_ready_a, 1);

        // Single bit
        clear_logs();
        send(8'h10);
        wait_idle();
        chk("single_n", log_a.size(), 1);
        if (log_a.size() == 1) begin
            chk("single_code", log_a[0].code, 4);
            chk("single_last", log_a[0].last, 1);
            chk("single_rem", log_a[0].rem, 1);
        end
        chk("single_after_valid", code_valid_a, 0);
        chk("single_after_ready", req_ready_a, 1);

        // Full vector, both priority orders
        clear_logs();
        send(8'hFF);
        wait_idle();
        chk("full_n_a", log_a.size(), 8);
        chk("full_n_b", log_b.size(), 8);
        if (log_a.size() == 8 && log_b.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("full_code_a", log_a[i].code, 7 - i);
                chk("full_code_b", log_b[i].code, i);
                chk("full_rem_a", log_a[i].rem, 8 - i);
                chk("full_last_a", log_a[i].last, i == 7);
            end
            chk("full_span", log_a[7].cyc - log_a[0].cyc, 7);
        end

        // Backpressure
        clear_logs();
        code_ready = 1'b0;
        send(8'h81);
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", code_valid_a, 1);
            chk("bp_code_a", code_a, 7);
            chk("bp_code_b", code_b, 0);
            chk("bp_rem", remaining_a, 2);
            chk("bp_last", last_a, 0);
        end
        code_ready = 1'b1;
        wait_idle();
        chk("bp_n", log_a.size(), 2);
        if (log_a.size() == 2) begin
            chk("bp_first", log_a[0].code, 7);
            chk("bp_second", log_a[1].code, 0);
            chk("bp_second_last", log_a[1].last, 1);
        end

        // Zero vector is swallowed
        clear_logs();
        send(8'h00);
        repeat (3) begin
            @(negedge clk);
            chk("zero_valid", code_valid_a, 0);
        end
        chk("zero_n", log_a.size(), 0);

        // Enable gating
        @(posedge clk);
        #1 en = 1'b0;
        req = 8'h03;
        req_valid = 1'b1;
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            chk("en_off_ready", req_ready_a, 0);
            chk("en_off_valid", code_valid_a, 0);
        end
        en = 1'b1;
        send(8'h03);
        wait_idle();
        chk("en_n", log_a.size(), 2);
        if (log_a.size() == 2 && log_b.size() == 2) begin
            chk("en_code0_a", log_a[0].code, 1);
            chk("en_code1_a", log_a[1].code, 0);
            chk("en_code0_b", log_b[0].code, 0);
            chk("en_code1_b", log_b[1].code, 1);
        end

        // Back-to-back vectors
        clear_logs();
        send(8'h06);
        send(8'h01);
        wait_idle();
        chk("b2b_n", log_a.size(), 3);
        if (log_a.size() == 3) begin
            chk("b2b_c0", log_a[0].code, 2);
            chk("b2b_c1", log_a[1].code, 1);
            chk("b2b_c1_last", log_a[1].last, 1);
            chk("b2b_c2", log_a[2].code, 0);
            chk("b2b_gap01", log_a[1].cyc - log_a[0].cyc, 1);
            chk("b2b_gap12", log_a[2].cyc - log_a[1].cyc, 2);
        end

        // Reset in the middle of serving
        code_ready = 1'b0;
        send(8'hA5);
        @(negedge clk);
        chk("mid_valid", code_valid_a, 1);
        chk("mid_rem", remaining_a, 4);
        chk("mid_code_a", code_a, 7);
        chk("mid_code_b", code_b, 0);
        #2 rst_n = 1'b0;
        #1 chk_zero("mid_reset");
        clear_logs();
        @(negedge clk);
        rst_n = 1'b1;
        code_ready = 1'b1;
        #1 chk("mid_release_ready", req_ready_a, 0);
        @(posedge clk);
        #1 chk("mid_first_edge_ready", req_ready_a, 1);
        repeat (10) @(negedge clk);
        chk("mid_stale_a", log_a.size(), 0);
        chk("mid_stale_b", log_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
